// File: rtl/btn_evt_pkg.sv
// Shared types and defaults for the badge button event reader.
// Build option: define BTN_EVT_RELEASE_EN to queue release events as well as presses.
package btn_evt_pkg;

  // Wide enough for the largest supported button count (16).
  localparam int BTN_IDX_W     = 4;
  localparam int TICK_DIV_DEF  = 48000;
  localparam int DEB_TICKS_DEF = 10;

  typedef struct packed {
    logic [BTN_IDX_W-1:0] index;
    logic                 press;
  } btn_evt_t;

  // Bit width needed to address n items, never less than one bit.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Per-button debouncer: flips its level after DEB_TICKS consecutive ticks
// on which the synchronized input disagrees with the current level.
module btn_debounce
  import btn_evt_pkg::*;
#(
  parameter int DEB_TICKS = DEB_TICKS_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  input  logic tick,
  output logic level,
  output logic change
);

  logic [7:0] cnt_r;
  logic       level_r;

  // Change is combinational so the caller can record it on the same edge the level flips.
  always_comb begin
    change = 1'b0;
    if (tick && (din != level_r) && (cnt_r == 8'(DEB_TICKS - 1))) begin
      change = 1'b1;
    end else begin
      change = 1'b0;
    end
  end

  // Stability counter and debounced level, advanced only on the shared tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= 8'd0;
      level_r <= 1'b0;
    end else if (tick) begin
      if (din == level_r) begin
        cnt_r <= 8'd0;
      end else if (change) begin
        cnt_r   <= 8'd0;
        level_r <= ~level_r;
      end else begin
        cnt_r <= cnt_r + 8'd1;
      end
    end else begin
      cnt_r   <= cnt_r;
      level_r <= level_r;
    end
  end

  assign level = level_r;

endmodule

// File: rtl/btn_event_reader.sv
// Badge button reader: synchronizes and debounces the active-low pins, turns
// level changes into press/release events and queues them for a consumer.
// Build option: BTN_EVT_RELEASE_EN queues releases too; without it only presses
// are queued, evt_press is constant 1 and overflow never pulses.
module btn_event_reader
  import btn_evt_pkg::*;
#(
  parameter int NBTN       = 8,
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int DEB_TICKS  = DEB_TICKS_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NBTN-1:0]                        nbtn,
  output logic [NBTN-1:0]                        btn_level,
  output logic                                   evt_valid,
  input  logic                                   evt_ready,
  output logic [((NBTN > 1) ? $clog2(NBTN) : 1)-1:0] evt_index,
  output logic                                   evt_press,
  output logic                                   overflow
);

  localparam int IDX_W = addr_w(NBTN);
  localparam int DIV_W = addr_w(TICK_DIV);
  localparam int PTR_W = addr_w(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

`ifdef BTN_EVT_RELEASE_EN
  localparam logic PRESS_RST = 1'b0;
`else
  // Every stored entry, reset contents included, carries press=1 in press-only builds.
  localparam logic PRESS_RST = 1'b1;
`endif
  localparam btn_evt_t EVT_RST = '{index: {BTN_IDX_W{1'b0}}, press: PRESS_RST};

  logic [NBTN-1:0]  sync1_r, sync2_r, pressed_s;
  logic [NBTN-1:0]  level_s, change_s, post_s, coal_s, grant_s;
  logic [NBTN-1:0]  pend_r, pend_dir_r;
  logic [DIV_W-1:0] div_r;
  logic             tick_s;
  btn_evt_t         mem_r [FIFO_DEPTH];
  btn_evt_t         wr_evt_s, head_s;
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             valid_r, overflow_r, push_s, pop_s, can_push_s;

  // Two-flop synchronizer; resets to the released (high) pin state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= {NBTN{1'b1}};
      sync2_r <= {NBTN{1'b1}};
    end else begin
      sync1_r <= nbtn;
      sync2_r <= sync1_r;
    end
  end

  assign pressed_s = ~sync2_r;

  // Free-running prescaler for the debounce tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r <= {DIV_W{1'b0}};
    end else if (div_r == DIV_W'(TICK_DIV - 1)) begin
      div_r <= {DIV_W{1'b0}};
    end else begin
      div_r <= div_r + DIV_W'(1);
    end
  end

  assign tick_s = (div_r == DIV_W'(TICK_DIV - 1));

  for (genvar g = 0; g < NBTN; g++) begin : g_deb
    btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .din    (pressed_s[g]),
      .tick   (tick_s),
      .level  (level_s[g]),
      .change (change_s[g])
    );
  end

  assign btn_level = level_s;

  // Select which level changes become events; the new direction equals the synchronized input.
  always_comb begin
`ifdef BTN_EVT_RELEASE_EN
    post_s = change_s;
`else
    post_s = change_s & pressed_s;
`endif
  end

  // Arbiter: lowest-index pending button wins the single push slot when there is room.
  always_comb begin
    grant_s    = {NBTN{1'b0}};
    push_s     = 1'b0;
    wr_evt_s   = '{index: {BTN_IDX_W{1'b0}}, press: 1'b0};
    pop_s      = valid_r & evt_ready;
    can_push_s = (count_r != CNT_W'(FIFO_DEPTH)) | pop_s;
    for (int i = 0; i < NBTN; i++) begin
      if (can_push_s && pend_r[i] && !push_s) begin
        grant_s[i]     = 1'b1;
        push_s         = 1'b1;
        wr_evt_s.index = BTN_IDX_W'(i);
        wr_evt_s.press = pend_dir_r[i];
      end else begin
        grant_s[i] = 1'b0;
      end
    end
  end

  // An opposite-direction change on a still-pending button cancels both changes.
  always_comb begin
    coal_s = post_s & pend_r & ~grant_s & (pend_dir_r ^ pressed_s);
  end

  // Pending bits: set on a posted change, cleared by a grant or by coalescing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r     <= {NBTN{1'b0}};
      pend_dir_r <= {NBTN{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        if (post_s[i]) begin
          if (coal_s[i]) begin
            pend_r[i] <= 1'b0;
          end else begin
            pend_r[i]     <= 1'b1;
            pend_dir_r[i] <= pressed_s[i];
          end
        end else if (grant_s[i]) begin
          pend_r[i] <= 1'b0;
        end else begin
          pend_r[i] <= pend_r[i];
        end
      end
      overflow_r <= |coal_s;
    end
  end

  // Event FIFO; valid excludes the entry written this cycle, giving one cycle of latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= EVT_RST;
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      valid_r  <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= wr_evt_s;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      valid_r <= (count_r != CNT_W'(0)) && !(pop_s && (count_r == CNT_W'(1)));
    end
  end

  assign head_s    = mem_r[rd_ptr_r];
  assign evt_valid = valid_r;
  assign evt_index = IDX_W'(head_s.index);
  assign evt_press = head_s.press;
  assign overflow  = overflow_r;

endmodule
